// File: rtl/coherence_control.sv
// coherence_control: two-core snooping coherence controller in front of a
// single-ported RAM. It serves one transaction at a time: an instruction
// fetch, a dcache write-back, or a two-word dcache block read. A block read
// first snoops the other core, and if that core holds the block dirty, the
// dirty words are written to RAM before the requester gets the block.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   iREN/iaddr            per-core fetch request / address
//   iwait/iload           per-core fetch stall / shared fetch data
//   dREN/dWEN             per-core dcache read / write-back request
//   daddr/dstore          per-core dcache word address / write data
//   dwait/dload           per-core dcache stall / read data
//   cctrans/ccwrite       requester: miss / write intent; snooper: present / dirty
//   ccwait/ccinv          per-core snoop hold / invalidate
//   ccsnoopaddr           per-core snoop block address
//   ramREN/ramWEN         RAM read / write strobes
//   ramaddr/ramstore      RAM address / write data
//   ramload/ramstate      RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//
// Build option
//   CC_TRANSFER_EN   When defined, dirty words are also forwarded straight to
//                    the requester while they are written to RAM. When
//                    undefined, the requester rereads the block from RAM
//                    after the write-back.
module coherence_control (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [31:0]      iload,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [2:0] WORD0_OFF  = 3'b000;
  localparam logic [2:0] WORD1_OFF  = 3'b100;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ARB    = 4'd1,
    IFETCH = 4'd2,
    WB     = 4'd3,
    SNOOP  = 4'd4,
    FWD0   = 4'd5,
    FWD1   = 4'd6,
    RD0    = 4'd7,
    RD1    = 4'd8
  } state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;     // core that owns the current transaction
  logic   last_q, last_d;   // core granted most recently (round-robin)
  logic   inv_q, inv_d;     // invalidate flag captured during SNOOP

  logic        oth;
  logic        access;
  logic [1:0]  elig;
  logic        pick;
  logic [31:0] blk_addr;

  // State registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      inv_q   <= inv_d;
    end
  end

  // Arbitration: highest request class present, round-robin among its cores
  always_comb begin
    elig = 2'b00;
    pick = 1'b0;
    if (|dWEN)      elig = dWEN;
    else if (|dREN) elig = dREN;
    else            elig = iREN;
    if (elig == 2'b11) pick = ~last_q;
    else               pick = elig[1];
  end

  assign oth      = ~gnt_q;
  assign access   = (ramstate == RAM_ACCESS);
  assign blk_addr = {daddr[gnt_q][31:3], WORD0_OFF};

  // Next state and outputs
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    inv_d       = inv_q;
    iwait       = 2'b11;
    iload       = '0;
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    // The snooped core stays held for the whole block transaction
    if (state_q inside {SNOOP, FWD0, FWD1, RD0, RD1}) begin
      ccwait[oth]      = 1'b1;
      ccsnoopaddr[oth] = blk_addr;
      ccinv[oth]       = (state_q == SNOOP) ? ccwrite[gnt_q] : inv_q;
    end

    case (state_q)
      IDLE: begin
        if (|{iREN, dREN, dWEN}) state_d = ARB;
      end

      ARB: begin
        // Requests withdrawn since IDLE are simply dropped
        if (elig == 2'b00) begin
          state_d = IDLE;
        end else begin
          gnt_d  = pick;
          last_d = pick;
          if (|dWEN)      state_d = WB;
          else if (|dREN) state_d = SNOOP;
          else            state_d = IFETCH;
        end
      end

      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[gnt_q];
        if (access) begin
          iwait[gnt_q] = 1'b0;
          iload        = ramload;
          state_d      = IDLE;
        end
      end

      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[gnt_q];
        ramstore = dstore[gnt_q];
        if (access) begin
          dwait[gnt_q] = 1'b0;
          state_d      = IDLE;
        end
      end

      SNOOP: begin
        inv_d   = ccwrite[gnt_q];
        state_d = (cctrans[oth] && ccwrite[oth]) ? FWD0 : RD0;
      end

      FWD0, FWD1: begin
        // The snooper drives its dirty words out through its own write port
        ramWEN   = dWEN[oth];
        ramaddr  = daddr[oth];
        ramstore = dstore[oth];
        if (access && dWEN[oth]) begin
          dwait[oth] = 1'b0;
`ifdef CC_TRANSFER_EN
          dwait[gnt_q] = 1'b0;
          dload[gnt_q] = dstore[oth];
          state_d      = (state_q == FWD0) ? FWD1 : IDLE;
`else
          state_d      = (state_q == FWD0) ? FWD1 : RD0;
`endif
        end
      end

      RD0, RD1: begin
        ramREN  = 1'b1;
        ramaddr = {daddr[gnt_q][31:3], (state_q == RD0) ? WORD0_OFF : WORD1_OFF};
        if (access) begin
          dwait[gnt_q] = 1'b0;
          dload[gnt_q] = ramload;
          state_d      = (state_q == RD0) ? RD1 : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/coherence_control.md
COHERENCE_CONTROL -- requirements
Module: coherence_control

Interface
REQ-001 SHALL have ports: CLK in 1, system clock; single clock domain, all state on rising edge.
REQ-002 SHALL have RST in 1, asynchronous, active-high reset.
REQ-003 SHALL have iREN in [1:0] and iaddr in [1:0][31:0], per-core instruction fetch request and address.
REQ-004 SHALL have iwait out [1:0] and iload out [31:0], per-core fetch stall and shared fetch data.
REQ-005 SHALL have dREN, dWEN in [1:0], per-core dcache word read and write (evict) request.
REQ-006 SHALL have daddr, dstore in [1:0][31:0], per-core dcache word address and write data.
REQ-007 SHALL have dwait out [1:0] and dload out [1:0][31:0], per-core dcache stall and read data.
REQ-008 SHALL have cctrans, ccwrite in [1:0]: as requester = miss transaction / write intent; as snooper = block present / block dirty.
REQ-009 SHALL have ccwait, ccinv out [1:0] and ccsnoopaddr out [1:0][31:0], per-core snoop hold, invalidate, snoop address.
REQ-010 SHALL have ramREN, ramWEN out 1, ramaddr, ramstore out [31:0], ramload in [31:0], ramstate in [1:0] (FREE=0, BUSY=1, ACCESS=2, ERROR=3).

Function
REQ-011 SHALL implement states IDLE, ARB, IFETCH, WB, SNOOP, FWD0, FWD1, RD0, RD1; one transaction at a time.
REQ-012 IDLE->ARB when any iREN/dREN/dWEN asserted; ARB grants one core, one request, in one cycle.
REQ-013 Priority: dWEN over dREN over iREN; between cores round-robin on register last: if both eligible grant core != last; last <= granted core.
REQ-014 WB: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g]; dwait[g]=0 only in cycle ramstate==ACCESS; then IDLE.
REQ-015 IFETCH: ramREN=1, ramaddr=iaddr[g]; iwait[g]=0, iload=ramload in ACCESS cycle; then IDLE.
REQ-016 dREN grant (o = other core) -> SNOOP for exactly one cycle: ccwait[o]=1, ccsnoopaddr[o]={daddr[g][31:3],3'b000}, ccinv[o]=ccwrite[g].
REQ-017 At end of SNOOP: cctrans[o]&ccwrite[o] -> FWD0; else RD0.
REQ-018 ccwait[o] SHALL stay 1 from SNOOP through exit of FWD1 or RD1; ccinv[o] and ccsnoopaddr[o] held likewise.
REQ-019 FWD0/FWD1: RAM write of dstore[o] to daddr[o] on snooper dWEN[o]; dwait[o]=0 in ACCESS cycle; FWD0 word offset 0, FWD1 offset 4.
REQ-020 RD0/RD1: ramREN=1, ramaddr={daddr[g][31:3],3'b000}/{..,3'b100}; dwait[g]=0, dload[g]=ramload in ACCESS; RD1 exit -> IDLE.
REQ-021 ramstate BUSY, FREE or ERROR SHALL leave state unchanged and waits asserted (ERROR retried).
REQ-022 Non-granted core outputs: dwait=1, iwait=1; all non-driving RAM outputs 0.
REQ-023 A request deasserted before grant SHALL be dropped without RAM activity.
REQ-024 dwait/iwait SHALL be low at most one cycle per word; no two RAM strobes asserted together.

Reset
REQ-025 RST SHALL force IDLE, last=1 (core 0 first), iwait=dwait=2'b11, ccwait=ccinv=0, ccsnoopaddr=0, dload=0, iload=0, ram* outputs 0, immediately, including mid-transaction.
REQ-026 After RST release, an in-flight transaction SHALL NOT resume; caches reissue.

Configuration
REQ-027 Macro CC_TRANSFER_EN defined: in FWD0/FWD1 dload[g]=dstore[o] and dwait[g]=0 in same ACCESS cycle; FWD1 exit -> IDLE.
REQ-028 CC_TRANSFER_EN undefined: FWD0/FWD1 write RAM only, dwait[g] held 1; FWD1 exit -> RD0 to refetch from RAM.

Verification
REQ-029 Core0 iREN, iaddr=0x100, ramstate ACCESS after 2 BUSY -> ramREN 3 cycles, iwait[0] low 1 cycle, iload=ramload.
REQ-030 Both cores dREN same cycle after reset -> core0 served first, core1 next; ccwait[1]=1 during core0 transaction.
REQ-031 Core0 dREN 0x208 cctrans=1 ccwrite=1, core1 snoop cctrans=1 ccwrite=0 -> ccsnoopaddr[1]=0x208, ccinv[1]=1, RD0/RD1 reads 0x208, 0x20C.
REQ-032 Core1 dirty (ccwrite[1]=1), supplies 0xDEAD/0xBEEF -> RAM writes 0x208/0x20C; with CC_TRANSFER_EN dload[0]=0xDEAD then 0xBEEF; without, dload from RD0/RD1.
REQ-033 RST asserted during RD0 with ramREN=1 -> same-cycle ramREN=0, dwait=2'b11, ccwait=0; next request arbitrates from IDLE.
REQ-034 Core0 dWEN and core1 iREN together, ramstate ERROR 3 cycles then ACCESS -> WB held, ramWEN stays 1, then IFETCH for core1.
